// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_wr_ctrl
// Purpose  : Write-side pointer and flag controller for a dual-clock FIFO.
//            Keeps the binary write pointer for the RAM and a registered Gray
//            copy of it for the read domain. Brings the Gray read pointer
//            into wr_clk through a two-flop synchronizer. Produces a
//            registered full flag with zero-cycle latency from the write
//            that fills the FIFO.
// Ports    : wr_clk      - write-domain clock
//            wr_rst_n    - asynchronous active-low reset
//            wr_en       - producer write request
//            rd_ptr_gray - Gray read pointer from the read domain (async)
//            wrt_ptr     - binary write pointer (address + wrap bit)
//            wr_ptr_gray - registered Gray copy of wrt_ptr
//            full        - FIFO full (also gates RAM writes)
//            wr_ack      - one-cycle pulse per accepted write
//            overflow    - one-cycle pulse per write rejected while full
//            almost_full - fill level >= AF_THRESH (optional)
// Options  : define ASYNC_FIFO_ALMOST_FULL_EN to add the almost_full port
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl #(
  parameter int PTR_LEN   = 4,
  parameter int AF_THRESH = 2**PTR_LEN - 2
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic               wr_en,
  input  logic [PTR_LEN:0]   rd_ptr_gray,
  output logic [PTR_LEN:0]   wrt_ptr,
  output logic [PTR_LEN:0]   wr_ptr_gray,
  output logic               full,
  output logic               wr_ack,
  output logic               overflow
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  ,
  output logic               almost_full
`endif
);

  // Read-pointer synchronizer stages; nothing sits between them.
  logic [PTR_LEN:0] rq1;
  logic [PTR_LEN:0] rq2;

  logic             push;
  logic [PTR_LEN:0] ptr_next;
  logic [PTR_LEN:0] gray_next;
  logic             full_next;

  // A write is taken only when the registered full flag is low.
  assign push      = wr_en & ~full;
  assign ptr_next  = wrt_ptr + {{PTR_LEN{1'b0}}, push};
  assign gray_next = ptr_next ^ (ptr_next >> 1);

  // Full when the next write pointer is exactly one lap ahead of the
  // synchronized read pointer: in Gray code that means the top two bits
  // differ and the rest match.
  assign full_next = (gray_next == {~rq2[PTR_LEN:PTR_LEN-1], rq2[PTR_LEN-2:0]});

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rd_ptr_gray;
      rq2 <= rq1;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wrt_ptr     <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wrt_ptr     <= ptr_next;
      wr_ptr_gray <= gray_next;
      full        <= full_next;
      wr_ack      <= push;
      overflow    <= wr_en & full;
    end
  end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam logic [PTR_LEN:0] AF_LIMIT = (PTR_LEN+1)'(AF_THRESH);

  logic [PTR_LEN:0] rq2_bin;
  logic [PTR_LEN:0] level;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rq2_bin = '0;
    for (int i = 0; i <= PTR_LEN; i++) begin
      rq2_bin[i] = ^(rq2 >> i);
    end
  end

  // Modulo subtraction yields the fill level even across pointer wrap.
  assign level = ptr_next - rq2_bin;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (level >= AF_LIMIT);
    end
  end
`endif

endmodule
`default_nettype wire
